// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared types and default widths for the reg_file command
//                controller (command opcodes, controller FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  localparam int c_ADDR_WIDTH = 3;
  localparam int c_REG_WIDTH  = 32;
  localparam int c_CNT_WIDTH  = 16;

  // Command opcodes as carried on i_cmd_op
  typedef enum logic [1:0] {
    OP_READ2   = 2'b00,
    OP_WRITE   = 2'b01,
    OP_RMW     = 2'b10,
    OP_ILLEGAL = 2'b11
  } rf_op_e;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WRITE = 2'b10,
    ST_RSP   = 2'b11
  } rf_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/reg_file_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_ctrl
//  Description : Command-driven initiator for reg_file. Accepts READ2, WRITE
//                and read-modify-write commands on a valid/ready channel,
//                sequences the reg_file read/write ports and returns read
//                data on a valid/ready response channel.
//                Build option RF_ZERO_REG_EN: register 0 reads as zero and
//                is never written.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_ctrl
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = c_ADDR_WIDTH,
  parameter int REG_WIDTH  = c_REG_WIDTH,
  parameter int CNT_WIDTH  = c_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr_b,
  input  logic [REG_WIDTH-1:0]  i_cmd_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [REG_WIDTH-1:0]  o_rsp_a_data,
  output logic [REG_WIDTH-1:0]  o_rsp_b_data,
  output logic                  o_err,
  output logic [CNT_WIDTH-1:0]  o_cmd_count,
  output logic [ADDR_WIDTH-1:0] o_rf_a_addr,
  output logic [ADDR_WIDTH-1:0] o_rf_b_addr,
  input  logic [REG_WIDTH-1:0]  i_rf_a_val,
  input  logic [REG_WIDTH-1:0]  i_rf_b_val,
  output logic [ADDR_WIDTH-1:0] o_rf_w_addr,
  output logic [REG_WIDTH-1:0]  o_rf_w_val,
  output logic                  o_rf_write_en
);

  rf_ctrl_state_e        r_state;
  rf_ctrl_state_e        w_next_state;
  rf_op_e                r_op;
  rf_op_e                w_cmd_op;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic [REG_WIDTH-1:0]  r_wdata;
  logic [REG_WIDTH-1:0]  r_rsp_a;
  logic [REG_WIDTH-1:0]  r_rsp_b;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_cmd_count;

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_write_en;
  logic                  w_cmd_done;
  logic                  w_wr_allowed;
  logic [REG_WIDTH-1:0]  w_rd_a_val;
  logic [REG_WIDTH-1:0]  w_rd_b_val;

  assign w_cmd_op = rf_op_e'(i_cmd_op);
  assign w_legal  = (w_cmd_op != OP_ILLEGAL);

  // Ready/valid/write-enable are gated by reset so nothing leaks out during
  // the reset cycle, even when reset lands mid-operation.
  assign o_cmd_ready   = (r_state == ST_IDLE) && !i_rst;
  assign o_rsp_valid   = (r_state == ST_RSP) && !i_rst;
  assign o_rf_write_en = w_write_en && !i_rst;
  assign w_accept      = i_cmd_valid && o_cmd_ready;

`ifdef RF_ZERO_REG_EN
  // Register 0 is hardwired zero: suppress its writes and mask its reads.
  assign w_wr_allowed = (r_addr_a != '0);
  assign w_rd_a_val   = (r_addr_a == '0) ? '0 : i_rf_a_val;
  assign w_rd_b_val   = (r_addr_b == '0) ? '0 : i_rf_b_val;
`else
  assign w_wr_allowed = 1'b1;
  assign w_rd_a_val   = i_rf_a_val;
  assign w_rd_b_val   = i_rf_b_val;
`endif

  assign o_rf_a_addr  = r_addr_a;
  assign o_rf_b_addr  = r_addr_b;
  assign o_rf_w_addr  = r_addr_a;
  assign o_rf_w_val   = r_wdata;
  assign o_rsp_a_data = r_rsp_a;
  assign o_rsp_b_data = r_rsp_b;
  assign o_err        = r_err;
  assign o_cmd_count  = r_cmd_count;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state, write strobe and command-completion decode
  always_comb begin
    w_next_state = r_state;
    w_write_en   = 1'b0;
    w_cmd_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_cmd_op)
            OP_READ2: w_next_state = ST_ISSUE;
            OP_RMW:   w_next_state = ST_ISSUE;
            OP_WRITE: w_next_state = ST_WRITE;
            default:  w_next_state = ST_IDLE;
          endcase
        end
      end
      ST_ISSUE: begin
        // Read happens here, before the write strobe, so RMW sees the old value.
        w_next_state = (r_op == OP_RMW) ? ST_WRITE : ST_RSP;
      end
      ST_WRITE: begin
        w_write_en = w_wr_allowed;
        if (r_op == OP_WRITE) begin
          w_next_state = ST_IDLE;
          w_cmd_done   = 1'b1;
        end else begin
          w_next_state = ST_RSP;
        end
      end
      ST_RSP: begin
        if (i_rsp_ready) begin
          w_next_state = ST_IDLE;
          w_cmd_done   = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Command latch and response capture; illegal ops leave the rf addresses untouched
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= OP_READ2;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_wdata  <= '0;
      r_rsp_a  <= '0;
      r_rsp_b  <= '0;
    end else begin
      if (w_accept && w_legal) begin
        r_op     <= w_cmd_op;
        r_addr_a <= i_cmd_addr_a;
        r_addr_b <= i_cmd_addr_b;
        r_wdata  <= i_cmd_wdata;
      end
      if (r_state == ST_ISSUE) begin
        r_rsp_a <= w_rd_a_val;
        r_rsp_b <= (r_op == OP_RMW) ? '0 : w_rd_b_val;
      end
    end
  end

  // One-cycle error pulse for an accepted illegal opcode
  always_ff @(posedge i_clk) begin
    if (i_rst) r_err <= 1'b0;
    else       r_err <= w_accept && !w_legal;
  end

  // Completed-command counter, wraps naturally
  always_ff @(posedge i_clk) begin
    if (i_rst)           r_cmd_count <= '0;
    else if (w_cmd_done) r_cmd_count <= r_cmd_count + 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_ctrl
//  Description : Directed self-checking bench for reg_file_ctrl paired with a
//                small behavioural reg_file (combinational read with write
//                bypass). Honours RF_ZERO_REG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_addr_a;
  logic [2:0]  cmd_addr_b;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_a_data;
  logic [31:0] rsp_b_data;
  logic        err;
  logic [15:0] cmd_count;
  logic [2:0]  rf_a_addr;
  logic [2:0]  rf_b_addr;
  logic [31:0] rf_a_val;
  logic [31:0] rf_b_val;
  logic [2:0]  rf_w_addr;
  logic [31:0] rf_w_val;
  logic        rf_we;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_ctrl #(.ADDR_WIDTH(3), .REG_WIDTH(32), .CNT_WIDTH(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_op     (cmd_op),
    .i_cmd_addr_a (cmd_addr_a),
    .i_cmd_addr_b (cmd_addr_b),
    .i_cmd_wdata  (cmd_wdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_a_data (rsp_a_data),
    .o_rsp_b_data (rsp_b_data),
    .o_err        (err),
    .o_cmd_count  (cmd_count),
    .o_rf_a_addr  (rf_a_addr),
    .o_rf_b_addr  (rf_b_addr),
    .i_rf_a_val   (rf_a_val),
    .i_rf_b_val   (rf_b_val),
    .o_rf_w_addr  (rf_w_addr),
    .o_rf_w_val   (rf_w_val),
    .o_rf_write_en(rf_we)
  );

  always #5 clk = ~clk;

  // Behavioural reg_file: combinational read with same-cycle write bypass
  logic [31:0] rf_mem [0:7];
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_w_addr] <= rf_w_val;
  end
  assign rf_a_val = (rf_we && rf_w_addr == rf_a_addr) ? rf_w_val : rf_mem[rf_a_addr];
  assign rf_b_val = (rf_we && rf_w_addr == rf_b_addr) ? rf_w_val : rf_mem[rf_b_addr];

`ifdef RF_ZERO_REG_EN
  localparam bit c_ZERO = 1'b1;
`else
  localparam bit c_ZERO = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return one cycle after the accepting edge
  task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                      input logic [31:0] d);
    int w = 0;
    while (!cmd_ready && w < 20) begin
      step();
      w++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: cmd_ready stuck at 0 after %0d cycles", w);
    end
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_wdata  = d;
    step();
    cmd_valid  = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    send(2'b01, a, 3'd0, d);
    step();
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [2:0] a, input logic [2:0] b,
                         input logic [31:0] ea, input logic [31:0] eb);
    send(2'b00, a, b, 32'h0);
    check({tag, "_valid_c1"}, 32'(rsp_valid), 32'd0);
    step();
    check({tag, "_valid_c2"}, 32'(rsp_valid), 32'd1);
    check({tag, "_a"}, rsp_a_data, ea);
    check({tag, "_b"}, rsp_b_data, eb);
    finish_rsp();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr_a = 3'd0;
    cmd_addr_b = 3'd0; cmd_wdata = 32'h0; rsp_ready = 1'b0;

    // 1. reset
    step(); step();
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(cmd_count), 32'd0);
    check("rst_rsp_a", rsp_a_data, 32'd0);
    check("rst_a_addr", 32'(rf_a_addr), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // 2. single write then read back, with latency
    send(2'b01, 3'd5, 3'd0, 32'hDEADBEEF);
    check("wr_we_c1", 32'(rf_we), 32'd1);
    check("wr_waddr", 32'(rf_w_addr), 32'd5);
    check("wr_wval", rf_w_val, 32'hDEADBEEF);
    step();
    check("wr_we_c2", 32'(rf_we), 32'd0);
    check("wr_count", 32'(cmd_count), 32'd1);
    do_read("rd5", 3'd5, 3'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    check("rd5_count", 32'(cmd_count), 32'd2);

    // 3. fill all registers, then hold a response under backpressure
    for (int i = 0; i < 8; i++) do_write(3'(i), 32'(i));
    check("fill_count", 32'(cmd_count), 32'd10);
    send(2'b00, 3'd6, 3'd7, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_a", rsp_a_data, 32'd6);
      check("bp_b", rsp_b_data, 32'd7);
      check("bp_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    finish_rsp();
    check("bp_done_valid", 32'(rsp_valid), 32'd0);
    check("hold_a_addr", 32'(rf_a_addr), 32'd6);
    check("hold_b_addr", 32'(rf_b_addr), 32'd7);
    check("bp_count", 32'(cmd_count), 32'd11);

    // 4. read-modify-write returns the old value
    do_write(3'd3, 32'h11);
    check("rmw_pre_count", 32'(cmd_count), 32'd12);
    send(2'b10, 3'd3, 3'd6, 32'h22);
    check("rmw_we_c1", 32'(rf_we), 32'd0);
    check("rmw_valid_c1", 32'(rsp_valid), 32'd0);
    step();
    check("rmw_we_c2", 32'(rf_we), 32'd1);
    check("rmw_waddr", 32'(rf_w_addr), 32'd3);
    check("rmw_wval", rf_w_val, 32'h22);
    check("rmw_valid_c2", 32'(rsp_valid), 32'd0);
    step();
    check("rmw_we_c3", 32'(rf_we), 32'd0);
    check("rmw_valid_c3", 32'(rsp_valid), 32'd1);
    check("rmw_a_old", rsp_a_data, 32'h11);
    check("rmw_b_zero", rsp_b_data, 32'h0);
    finish_rsp();
    do_read("rd3", 3'd3, 3'd3, 32'h22, 32'h22);
    check("rmw_count", 32'(cmd_count), 32'd14);

    // 5a. illegal opcode
    send(2'b11, 3'd1, 3'd1, 32'hFFFF_FFFF);
    check("ill_err_c1", 32'(err), 32'd1);
    check("ill_we", 32'(rf_we), 32'd0);
    check("ill_valid", 32'(rsp_valid), 32'd0);
    check("ill_ready", 32'(cmd_ready), 32'd1);
    check("ill_a_addr", 32'(rf_a_addr), 32'd3);
    step();
    check("ill_err_c2", 32'(err), 32'd0);
    check("ill_count", 32'(cmd_count), 32'd14);

    // 5b. reset while an RMW sits in ISSUE: the write must never happen
    do_write(3'd2, 32'h55);
    check("pre_abort_count", 32'(cmd_count), 32'd15);
    send(2'b10, 3'd2, 3'd0, 32'h99);
    rst = 1'b1;
    #1;
    check("abort_we_rst", 32'(rf_we), 32'd0);
    check("abort_ready_rst", 32'(cmd_ready), 32'd0);
    step();
    check("abort_we_rst2", 32'(rf_we), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_we_after", 32'(rf_we), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_count", 32'(cmd_count), 32'd0);
    step();
    check("abort_we_after2", 32'(rf_we), 32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    do_read("rd2", 3'd2, 3'd2, 32'h55, 32'h55);
    check("abort_rd_count", 32'(cmd_count), 32'd1);

    // 6. register 0 behaviour depends on build option
    send(2'b01, 3'd0, 3'd0, 32'hFF);
    check("z_we", 32'(rf_we), c_ZERO ? 32'd0 : 32'd1);
    step();
    check("z_count", 32'(cmd_count), 32'd2);
    do_read("rd0", 3'd0, 3'd0, c_ZERO ? 32'h0 : 32'hFF, c_ZERO ? 32'h0 : 32'hFF);
    check("z_rd_count", 32'(cmd_count), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
